// File: rtl/iter_div_pkg.sv
// Shared CPU definitions for the iterative divider and the hazard unit:
// divider state encoding, iteration count and EX-stage stall codes.
package iter_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // One restoring step per operand bit.
  localparam int DIV_CYCLES = 32;

  // Stall codes driven by the hazard unit; div_stop maps onto STALL_HOLD.
  localparam logic [1:0] STALL_NORMAL = 2'b00;
  localparam logic [1:0] STALL_HOLD   = 2'b01;
  localparam logic [1:0] STALL_FLUSH  = 2'b10;

endpackage

// File: rtl/iter_div_step.sv
// One combinational radix-2 restoring division step on {rem, quo}.
// The shifted partial remainder is WIDTH+1 bits wide so divisors with the
// top bit set still compare correctly; the difference always fits WIDTH bits
// whenever it is kept.
module div_step
  import iter_div_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted[WIDTH-1:0] - divisor;
  // Trial subtraction is non-negative when the shifted value reaches the divisor.
  assign fits    = shifted[WIDTH] | (shifted[WIDTH-1:0] >= divisor);

  // Keep the difference and shift in 1, or restore and shift in 0.
  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_next = diff;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle iterative divider (DIV/DIVU) for the EX stage.
// Magnitudes are divided with one restoring step per cycle, then the
// quotient/remainder signs are fixed up. div_stop holds EX until DONE.
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, a request whose
// |dividend| is below a non-zero |divisor| completes straight from IDLE.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             es_go,
  input  logic             flush,
  output logic             div_stop,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] divisor_mag;
  logic             sign1;
  logic             sign2;
  logic             is_signed;

  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic             early_out;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Quotient is negative when the operand signs differ.
  function automatic logic [WIDTH-1:0] fix_quo(input logic [WIDTH-1:0] mag,
                                               input logic sgn, input logic s1,
                                               input logic s2);
    return (sgn & (s1 ^ s2)) ? negate(mag) : mag;
  endfunction

  // Remainder takes the sign of the dividend.
  function automatic logic [WIDTH-1:0] fix_rem(input logic [WIDTH-1:0] mag,
                                               input logic sgn, input logic s1);
    return (sgn & s1) ? negate(mag) : mag;
  endfunction

  assign src1_neg = div_signed & src1[WIDTH-1];
  assign src2_neg = div_signed & src2[WIDTH-1];
  assign abs1     = src1_neg ? negate(src1) : src1;
  assign abs2     = src2_neg ? negate(src2) : src2;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (src2 != '0) && (abs1 < abs2);
`else
  assign early_out = 1'b0;
`endif

  // Hold EX from the request cycle until the result is ready.
  assign div_stop = div_req & (state != DIV_DONE) & ~flush;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_acc),
    .quo      (quo_acc),
    .divisor  (divisor_mag),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Divider FSM: operand capture, iteration, sign fixup and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= DIV_IDLE;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_done    <= 1'b0;
      rem_acc     <= '0;
      quo_acc     <= '0;
      divisor_mag <= '0;
      sign1       <= 1'b0;
      sign2       <= 1'b0;
      is_signed   <= 1'b0;
    end else if (flush) begin
      state    <= DIV_IDLE;
      div_done <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_req) begin
            if (early_out) begin
              state     <= DIV_DONE;
              div_done  <= 1'b1;
              quotient  <= '0;
              remainder <= src1;
            end else begin
              state       <= DIV_BUSY;
              count       <= '0;
              rem_acc     <= '0;
              quo_acc     <= abs1;
              divisor_mag <= abs2;
              sign1       <= src1[WIDTH-1];
              sign2       <= src2[WIDTH-1];
              is_signed   <= div_signed;
            end
          end
        end
        DIV_BUSY: begin
          rem_acc <= rem_step;
          quo_acc <= quo_step;
          count   <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state     <= DIV_DONE;
            div_done  <= 1'b1;
            quotient  <= fix_quo(quo_step, is_signed, sign1, sign2);
            remainder <= fix_rem(rem_step, is_signed, sign1);
          end
        end
        DIV_DONE: begin
          // Stay here until EX advances, even with div_req still high.
          if (es_go) begin
            state    <= DIV_IDLE;
            div_done <= 1'b0;
          end
        end
        default: begin
          state    <= DIV_IDLE;
          div_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: directed corner cases, randomized
// operands against an arithmetic reference, flush, hold-in-DONE,
// back-to-back requests and reset during an operation.
module tb_iter_div;

  logic        clk;
  logic        reset;
  logic        div_req;
  logic        div_signed;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        es_go;
  logic        flush;
  logic        div_stop;
  logic        div_done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_cmp = 0;
  int n_err = 0;

  iter_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_req    (div_req),
    .div_signed (div_signed),
    .src1       (src1),
    .src2       (src2),
    .es_go      (es_go),
    .flush      (flush),
    .div_stop   (div_stop),
    .div_done   (div_done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division on wide integers; divide-by-zero gives an
  // all-ones magnitude quotient and the dividend as remainder.
  function automatic void model(input bit sgn, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = a;
        sb = b;
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  function automatic logic [31:0] mag(input bit sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Start a division in the next cycle, wait for DONE, check results and
  // latency. With rel set, drop the request and confirm div_done clears.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit go, input bit rel, input string name);
    logic [31:0] eq, er;
    int lat, n, stops;
    model(sgn, a, b, eq, er);
    lat = 33;
`ifdef DIV_EARLY_OUT_EN
    if (b != 32'd0 && mag(sgn, a) < mag(sgn, b)) lat = 1;
`endif
    @(negedge clk);
    div_req = 1'b1; div_signed = sgn; src1 = a; src2 = b; es_go = go;
    n = 0; stops = 0;
    #1;
    while (!div_done && n < 100) begin
      if (div_stop) stops++;
      @(negedge clk);
      n++;
      src1 = $urandom; src2 = $urandom; div_signed = 1'($urandom);
      #1;
    end
    if (n !== lat) begin
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, lat);
      n_err++;
    end
    n_cmp++;
    if (stops !== lat) begin
      $display("FAIL %s div_stop cycles: got %0d, expected %0d", name, stops, lat);
      n_err++;
    end
    n_cmp++;
    if (quotient !== eq) begin
      $display("FAIL %s quotient: got %h, expected %h (a=%h b=%h s=%0d)", name, quotient, eq, a, b, sgn);
      n_err++;
    end
    n_cmp++;
    if (remainder !== er) begin
      $display("FAIL %s remainder: got %h, expected %h (a=%h b=%h s=%0d)", name, remainder, er, a, b, sgn);
      n_err++;
    end
    n_cmp++;
    if (div_stop !== 1'b0) begin
      $display("FAIL %s div_stop in DONE: got %b, expected 0", name, div_stop);
      n_err++;
    end
    n_cmp++;
    if (rel) begin
      div_req = 1'b0;
      @(negedge clk);
      #1;
      if (div_done !== 1'b0) begin
        $display("FAIL %s div_done after es_go: got %b, expected 0", name, div_done);
        n_err++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; div_req = 1'b0; div_signed = 1'b0; src1 = '0; src2 = '0;
    es_go = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if ({div_done, div_stop} !== 2'b00 || quotient !== 32'd0 || remainder !== 32'd0) begin
      $display("FAIL reset_state: got done=%b stop=%b q=%h r=%h, expected all 0",
               div_done, div_stop, quotient, remainder);
      n_err++;
    end
    n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    do_div(1'b0, 32'd100, 32'd7, 1'b1, 1'b1, "divu_100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, "div_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, "div_7_m2");
    do_div(1'b0, 32'd7, 32'd0, 1'b1, 1'b1, "divu_7_0");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, "div_overflow");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, "div_m7_0");
    do_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 1'b1, "divu_big_divisor");
    do_div(1'b0, 32'd5, 32'd9, 1'b1, 1'b1, "divu_5_9");
    do_div(1'b1, 32'hFFFF_FFFB, 32'd9, 1'b1, 1'b1, "div_m5_9");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit sgn;
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(0, 15);
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = a >> $urandom_range(0, 31);
      endcase
      do_div(sgn, a, b, 1'b1, 1'b1, "random");
    end
  endtask

  task automatic test_flush();
    logic [31:0] held_q, held_r;
    held_q = quotient;
    held_r = remainder;
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; src1 = 32'd1000; src2 = 32'd3; es_go = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    if (div_stop !== 1'b0) begin
      $display("FAIL flush_stop: got %b, expected 0", div_stop);
      n_err++;
    end
    n_cmp++;
    @(negedge clk);
    flush = 1'b0; div_req = 1'b0;
    #1;
    if (div_done !== 1'b0 || quotient !== held_q || remainder !== held_r) begin
      $display("FAIL flush_hold: got done=%b q=%h r=%h, expected done=0 q=%h r=%h",
               div_done, quotient, remainder, held_q, held_r);
      n_err++;
    end
    n_cmp++;
    do_div(1'b0, 32'd9, 32'd3, 1'b1, 1'b1, "after_flush_9_3");
  endtask

  task automatic test_hold_done();
    logic [31:0] hq, hr;
    do_div(1'b1, 32'hFFFF_FC18, 32'd13, 1'b0, 1'b0, "hold_div");
    hq = quotient;
    hr = remainder;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      src1 = $urandom; src2 = $urandom;
      #1;
      if (div_done !== 1'b1 || div_stop !== 1'b0 || quotient !== hq || remainder !== hr) begin
        $display("FAIL hold_done cycle %0d: got done=%b stop=%b q=%h r=%h, expected done=1 stop=0 q=%h r=%h",
                 i, div_done, div_stop, quotient, remainder, hq, hr);
        n_err++;
      end
      n_cmp++;
    end
    @(negedge clk);
    es_go = 1'b1;
    do_div(1'b0, 32'd12345, 32'd100, 1'b1, 1'b1, "after_hold");
  endtask

  task automatic test_back_to_back();
    do_div(1'b0, 32'd77777, 32'd10, 1'b1, 1'b0, "b2b_first");
    do_div(1'b1, 32'h8000_0001, 32'd3, 1'b1, 1'b1, "b2b_second");
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; src1 = 32'd1000; src2 = 32'd7; es_go = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1; div_req = 1'b0;
    @(negedge clk);
    #1;
    if ({div_done, div_stop} !== 2'b00 || quotient !== 32'd0 || remainder !== 32'd0) begin
      $display("FAIL reset_in_busy: got done=%b stop=%b q=%h r=%h, expected all 0",
               div_done, div_stop, quotient, remainder);
      n_err++;
    end
    n_cmp++;
    reset = 1'b0;
    do_div(1'b0, 32'd50, 32'd6, 1'b1, 1'b1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_hold_done();
    test_back_to_back();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
